// File: rtl/scan_test_pkg.sv
// Shared types and constants for the scan test controller.
//   state_t    : sequencer state encoding
//   cnt_width  : bits needed to hold a count of 0..n
//   DEF_*      : default chain geometry
package scan_test_pkg;

    localparam int unsigned DEF_CHAIN_LEN   = 64;
    localparam int unsigned DEF_CHAINS      = 4;
    localparam int unsigned MAX_CAPTURE_CYC = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/scan_step_cnt.sv
// Loadable up-counter with enable, synchronous clear and terminal-count flag.
// The counter wraps to zero on the enabled step taken while last is high,
// so a phase of TERM steps needs no extra clear from the parent.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   clr          : synchronous clear (highest priority)
//   load/load_val: synchronous load
//   en           : count one step
//   last         : count equals TERM-1 (the current step is the final one)
module scan_step_cnt #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned TERM  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [WIDTH-1:0] count;

    assign last = (count == WIDTH'(TERM - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: shifts patterns from a source into the scan chains,
// runs capture cycles, and streams responses to a sink. Unloading of the
// response to pattern k overlaps with loading of pattern k+1.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   start, abort             : run control
//   num_patterns             : pattern count, latched on start
//   busy, done, pat_idx      : status
//   pat_valid/pat_data/pat_ready    : pattern source handshake
//   resp_valid/resp_data/resp_ready : response sink handshake
//   scan_en, scan_in, scan_out      : scan chain interface
//   cut_clk_en               : core clock enable
module scan_test_ctrl
    import scan_test_pkg::*;
#(
    parameter int unsigned CHAIN_LEN   = DEF_CHAIN_LEN,
    parameter int unsigned CHAINS      = DEF_CHAINS,
    parameter int unsigned CAPTURE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       num_patterns,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pat_idx,
    input  logic              pat_valid,
    input  logic [CHAINS-1:0] pat_data,
    output logic              pat_ready,
    output logic              resp_valid,
    output logic [CHAINS-1:0] resp_data,
    input  logic              resp_ready,
    output logic              scan_en,
    output logic [CHAINS-1:0] scan_in,
    input  logic [CHAINS-1:0] scan_out,
    output logic              cut_clk_en
);

    localparam int unsigned BIT_W = cnt_width(CHAIN_LEN);
    localparam int unsigned CAP_W = cnt_width(MAX_CAPTURE_CYC);

    state_t      state;
    logic [15:0] pat_cnt;
    logic [15:0] pat_total;

    logic in_shift, in_capture, in_unload;
    logic step, bit_last, cap_last;
    logic start_go, abort_go, cnt_clr;

    assign in_shift   = (state == S_SHIFT);
    assign in_capture = (state == S_CAPTURE);
    assign in_unload  = (state == S_UNLOAD);
    assign start_go   = (state == S_IDLE) && start;
    assign abort_go   = (state != S_IDLE) && abort;
    assign cnt_clr    = start_go || abort_go;

    // Handshake outputs are pure decodes of state and the opposite-side
    // input, so pat_ready never looks at pat_valid and resp_valid never
    // looks at resp_ready. A shift step moves one slice in and, once a
    // previous response is in the chain, one slice out at the same time.
    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        pat_idx    = pat_cnt;
        scan_en    = in_shift || in_unload;
        scan_in    = '0;
        pat_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        step       = 1'b0;
        if (in_shift) begin
            scan_in    = pat_data;
            pat_ready  = (pat_cnt == '0) || resp_ready;
            resp_valid = (pat_cnt != '0) && pat_valid;
            resp_data  = scan_out;
            step       = pat_valid && pat_ready;
        end else if (in_unload) begin
            resp_valid = 1'b1;
            resp_data  = scan_out;
            step       = resp_ready;
        end
        cut_clk_en = step || in_capture;
    end

    scan_step_cnt #(
        .WIDTH(BIT_W),
        .TERM (CHAIN_LEN)
    ) u_bit_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .load    (1'b0),
        .load_val('0),
        .en      (step),
        .last    (bit_last)
    );

    scan_step_cnt #(
        .WIDTH(CAP_W),
        .TERM (CAPTURE_CYC)
    ) u_cap_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .load    (1'b0),
        .load_val('0),
        .en      (in_capture),
        .last    (cap_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pat_cnt   <= '0;
            pat_total <= '0;
        end else if (abort_go) begin
            state     <= S_IDLE;
            pat_cnt   <= '0;
            pat_total <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pat_cnt   <= '0;
                        pat_total <= num_patterns;
                        state     <= (num_patterns != '0) ? S_SHIFT : S_DONE;
                    end
                end
                S_SHIFT: begin
                    if (step && bit_last) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (cap_last) begin
                        pat_cnt <= pat_cnt + 16'd1;
                        state   <= (pat_cnt + 16'd1 == pat_total) ? S_UNLOAD : S_SHIFT;
                    end
                end
                S_UNLOAD: begin
                    if (step && bit_last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    pat_cnt <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_test_ctrl.sv
module tb_scan_test_ctrl;

    localparam int unsigned L  = 4;
    localparam int unsigned CH = 2;
    localparam int unsigned C  = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [15:0]   num_patterns;
    logic          busy;
    logic          done;
    logic [15:0]   pat_idx;
    logic          pat_valid;
    logic [CH-1:0] pat_data;
    logic          pat_ready;
    logic          resp_valid;
    logic [CH-1:0] resp_data;
    logic          resp_ready;
    logic          scan_en;
    logic [CH-1:0] scan_in;
    logic [CH-1:0] scan_out;
    logic          cut_clk_en;

    int checks = 0;
    int errors = 0;

    logic [CH-1:0] tbl [L];

    scan_test_ctrl #(
        .CHAIN_LEN  (L),
        .CHAINS     (CH),
        .CAPTURE_CYC(C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .num_patterns(num_patterns),
        .busy        (busy),
        .done        (done),
        .pat_idx     (pat_idx),
        .pat_valid   (pat_valid),
        .pat_data    (pat_data),
        .pat_ready   (pat_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_ready  (resp_ready),
        .scan_en     (scan_en),
        .scan_in     (scan_in),
        .scan_out    (scan_out),
        .cut_clk_en  (cut_clk_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_scan_en"}, 32'(scan_en), 0);
        chk({tag, "_cut_clk_en"}, 32'(cut_clk_en), 0);
        chk({tag, "_pat_ready"}, 32'(pat_ready), 0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
        chk({tag, "_pat_idx"}, 32'(pat_idx), 0);
        chk({tag, "_scan_in"}, 32'(scan_in), 0);
        chk({tag, "_resp_data"}, 32'(resp_data), 0);
    endtask

    // Walks the expected schedule of a run: per pattern CHAIN_LEN accepted
    // shift slices then CAPTURE_CYC capture cycles, then CHAIN_LEN unload
    // slices, then one done cycle. mode 0: no stalls, mode 1: scripted
    // stalls (3 source drops mid-shift, 2 sink drops mid-unload), mode 2: random.
    task automatic run_pat(input int n, input int mode, output int done_cyc);
        int   cyc, stalls, xfers, tries;
        logic pv, rr, acc;
        start = 1'b1;
        num_patterns = 16'(n);
        tick();
        start = 1'b0;
        cyc = 1;
        stalls = 0;
        xfers = 0;
        for (int p = 0; p < n; p++) begin
            for (int s = 0; s < int'(L); s++) begin
                tries = 0;
                do begin
                    pv = 1'b1;
                    rr = 1'b1;
                    if (mode == 2 && tries < 3) begin
                        pv = ($urandom_range(0, 3) != 0);
                        rr = ($urandom_range(0, 3) != 0);
                    end
                    if (mode == 1 && p == 0 && s == 2 && tries < 3) pv = 1'b0;
                    pat_valid  = pv;
                    resp_ready = rr;
                    pat_data   = (mode == 2) ? CH'($urandom) : tbl[s];
                    scan_out   = CH'($urandom);
                    @(negedge clk);
                    acc = pv && (p == 0 || rr);
                    chk("sh_busy", 32'(busy), 1);
                    chk("sh_done", 32'(done), 0);
                    chk("sh_scan_en", 32'(scan_en), 1);
                    chk("sh_scan_in", 32'(scan_in), 32'(pat_data));
                    chk("sh_pat_ready", 32'(pat_ready), 32'(p == 0 || rr));
                    chk("sh_resp_valid", 32'(resp_valid), 32'(p > 0 && pv));
                    chk("sh_cut_clk_en", 32'(cut_clk_en), 32'(acc));
                    chk("sh_pat_idx", 32'(pat_idx), 32'(p));
                    if (acc && p > 0) begin
                        xfers++;
                        chk("sh_resp_data", 32'(resp_data), 32'(scan_out));
                    end
                    if (!acc) stalls++;
                    tries++;
                    tick();
                    cyc++;
                end while (!acc);
            end
            for (int c = 0; c < int'(C); c++) begin
                pat_valid  = 1'($urandom);
                resp_ready = 1'($urandom);
                @(negedge clk);
                chk("cap_scan_en", 32'(scan_en), 0);
                chk("cap_cut_clk_en", 32'(cut_clk_en), 1);
                chk("cap_pat_ready", 32'(pat_ready), 0);
                chk("cap_resp_valid", 32'(resp_valid), 0);
                chk("cap_pat_idx", 32'(pat_idx), 32'(p));
                tick();
                cyc++;
            end
        end
        for (int s = 0; s < int'(L); s++) begin
            tries = 0;
            do begin
                rr = 1'b1;
                if (mode == 2 && tries < 3) rr = ($urandom_range(0, 2) != 0);
                if (mode == 1 && s == 2 && tries < 2) rr = 1'b0;
                resp_ready = rr;
                pat_valid  = 1'($urandom);
                pat_data   = CH'($urandom);
                scan_out   = CH'($urandom);
                @(negedge clk);
                chk("ul_scan_en", 32'(scan_en), 1);
                chk("ul_scan_in", 32'(scan_in), 0);
                chk("ul_resp_valid", 32'(resp_valid), 1);
                chk("ul_pat_ready", 32'(pat_ready), 0);
                chk("ul_cut_clk_en", 32'(cut_clk_en), 32'(rr));
                chk("ul_pat_idx", 32'(pat_idx), 32'(n));
                chk("ul_resp_data", 32'(resp_data), 32'(scan_out));
                if (rr) xfers++;
                else stalls++;
                tries++;
                tick();
                cyc++;
            end while (!rr);
        end
        pat_valid  = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("dn_done", 32'(done), 1);
        chk("dn_busy", 32'(busy), 1);
        chk("dn_scan_en", 32'(scan_en), 0);
        chk("dn_cycle", 32'(cyc), 32'(1 + n * int'(L + C) + int'(L) + stalls));
        chk("resp_xfers", 32'(xfers), 32'(n * int'(L)));
        done_cyc = cyc;
        tick();
        @(negedge clk);
        chk_quiet("post_run");
        tick();
    endtask

    initial begin
        int dc;
        tbl[0] = 2'b01;
        tbl[1] = 2'b10;
        tbl[2] = 2'b11;
        tbl[3] = 2'b00;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        num_patterns = '0;
        pat_valid = 1'b0;
        pat_data = '0;
        resp_ready = 1'b0;
        scan_out = '0;
        #2;
        chk_quiet("reset");
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk_quiet("idle");
        tick();

        // Directed single pattern, fixed data, no stalls
        run_pat(1, 0, dc);
        chk("n1_done_cycle", 32'(dc), 10);

        // Three patterns, no stalls
        run_pat(3, 0, dc);
        chk("n3_done_cycle", 32'(dc), 20);

        // Scripted stalls add exactly five cycles
        run_pat(1, 1, dc);
        chk("stall_done_cycle", 32'(dc), 15);

        // Zero patterns goes straight to done
        start = 1'b1;
        num_patterns = '0;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("n0_done", 32'(done), 1);
        chk("n0_busy", 32'(busy), 1);
        chk("n0_scan_en", 32'(scan_en), 0);
        tick();
        @(negedge clk);
        chk_quiet("n0_after");
        tick();

        // Abort during capture
        start = 1'b1;
        num_patterns = 16'd2;
        tick();
        start = 1'b0;
        pat_valid = 1'b1;
        resp_ready = 1'b1;
        repeat (L) tick();
        abort = 1'b1;
        @(negedge clk);
        chk("ab_in_capture", 32'(scan_en), 0);
        chk("ab_cap_clk", 32'(cut_clk_en), 1);
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk_quiet("ab_after");
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("ab_no_done", 32'(done), 0);
            chk("ab_stays_idle", 32'(busy), 0);
        end
        pat_valid = 1'b0;
        resp_ready = 1'b0;
        tick();
        run_pat(1, 0, dc);
        chk("ab_rerun_done_cycle", 32'(dc), 10);

        // Asynchronous reset in the middle of unload
        start = 1'b1;
        num_patterns = 16'd1;
        tick();
        start = 1'b0;
        pat_valid = 1'b1;
        resp_ready = 1'b1;
        repeat (L + C) tick();
        @(negedge clk);
        chk("rs_in_unload", 32'(resp_valid & scan_en), 1);
        #2;
        rst = 1'b0;
        #1;
        chk_quiet("rs_async");
        start = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rs_start_ignored", 32'(busy), 0);
        start = 1'b0;
        rst = 1'b1;
        pat_valid = 1'b0;
        resp_ready = 1'b0;
        tick();
        @(negedge clk);
        chk_quiet("rs_released");
        tick();

        // Randomised runs with random stalls
        for (int r = 0; r < 6; r++) begin
            run_pat(int'($urandom_range(1, 4)), 2, dc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/scan_test_ctrl.md
# scan_test_ctrl

Sequencer for scan-based testing of the scan-ready SAYAC core. It drives scan-enable, the core clock enable and the scan-in lines. It also pulls test patterns from a pattern source and pushes captured responses to a response sink. Loading of pattern k+1 overlaps with unloading of the response to pattern k. The block sits between the on-chip or tester pattern interface and the scan chains of the logic netlist.

## Interface
Parameters:
- CHAIN_LEN, default 64: flip-flops per scan chain.
- CHAINS, default 4: number of parallel scan chains.
- CAPTURE_CYC, default 1: functional capture cycles per pattern (1..15).

Ports:
- clk, in, 1: single clock. All state changes on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a run. Sampled only in IDLE.
- abort, in, 1: synchronous abort.
- num_patterns, in, 16: pattern count, latched on start.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at the end of a run.
- pat_idx, out, 16: index of the pattern currently being loaded or captured.
- pat_valid, in, 1: pattern-slice valid from the source.
- pat_data, in, CHAINS: one bit per chain for this shift step.
- pat_ready, out, 1: block accepts the slice.
- resp_valid, out, 1: response slice valid to the sink.
- resp_data, out, CHAINS: response bits, equal to scan_out.
- resp_ready, in, 1: sink accepts the slice.
- scan_en, out, 1: 1 = shift mode, 0 = functional/capture mode.
- scan_in, out, CHAINS: serial data into the chains.
- scan_out, in, CHAINS: serial data from the chains.
- cut_clk_en, out, 1: core advances only in cycles where this is high.

## Operation
- States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE:
  - All outputs 0.
  - start=1 with num_patterns>0: go to SHIFT. Clear pat_cnt and bit_cnt; latch num_patterns.
  - start=1 with num_patterns=0: go directly to DONE.
- SHIFT:
  - scan_en=1, scan_in=pat_data.
  - pat_ready = (pat_cnt==0) | resp_ready.
  - resp_valid = (pat_cnt!=0) & pat_valid.
  - Step occurs when pat_valid & pat_ready. On a step: cut_clk_en=1 and bit_cnt++.
  - No step (stall): cut_clk_en=0; chain contents and counters hold.
  - Responses shifted out while pat_cnt==0 are discarded; resp_valid stays 0.
  - After step CHAIN_LEN: clear bit_cnt, go to CAPTURE.
- CAPTURE:
  - scan_en=0, cut_clk_en=1, pat_ready=0, resp_valid=0. Lasts exactly CAPTURE_CYC cycles.
  - On exit, pat_cnt++.
  - If pat_cnt then equals the latched count, go to UNLOAD; otherwise go to SHIFT.
- UNLOAD:
  - scan_en=1, scan_in=0, resp_valid=1, pat_ready=0.
  - Step on resp_ready: cut_clk_en=1. Stall otherwise.
  - After CHAIN_LEN steps, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- pat_idx = pat_cnt.
- start while busy is ignored.
- abort (any non-IDLE state): next cycle is IDLE with all outputs 0, counters cleared, and no done pulse. abort takes priority over every other transition.
- resp_valid must not depend on resp_ready. pat_ready must not depend on pat_valid.

## Timing
- All outputs reset to 0, and the state resets to IDLE, immediately on rst=0, independent of clk.
- Timeline, counting the edge that samples start as edge 0:
  - First SHIFT cycle is cycle 1.
  - With no stalls, done is high in cycle 1 + N·(CHAIN_LEN+CAPTURE_CYC) + CHAIN_LEN.
- Each stall cycle adds one cycle to the run.
- The last shift step of a pattern and the first capture cycle are back-to-back; there are no idle cycles between phases.
- Counter widths:
  - bit_cnt: clog2(CHAIN_LEN+1).
  - pat_cnt: 16 bits, compared with the latched count. There is no wrap, because the run ends at the count.
- Reset asserted mid-shift leaves the chain contents undefined. The controller restarts only on a new start.

## Structure
- Package scan_test_pkg holds:
  - the state enum type;
  - the localparam helper for counter width;
  - the default CHAIN_LEN and CHAINS constants.
- Sub-module scan_step_cnt: loadable up-counter with enable, synchronous clear and terminal-count flag. Instantiated for bit_cnt (terminal CHAIN_LEN) and for the capture-cycle count.
- pat_cnt is an inline register.

## Test plan
- CHAIN_LEN=4, CHAINS=2, CAPTURE_CYC=1, N=1, sink and source always ready:
  - pat_data 01,10,11,00 appears on scan_in in cycles 1–4.
  - One capture cycle follows with scan_en=0.
  - UNLOAD runs 4 cycles with resp_data equal to scan_out.
  - done pulses in cycle 10.
- N=3, no stalls:
  - resp_valid is low for the first 4 steps.
  - Exactly 12 response slices are transferred.
  - pat_idx steps 0,1,2.
  - done pulses in cycle 20.
- Stalls: drop pat_valid for 3 cycles mid-SHIFT and drop resp_ready for 2 cycles mid-UNLOAD.
  - cut_clk_en=0 and all counters hold during those cycles.
  - done is delayed by exactly 5 cycles.
- start with num_patterns=0: done pulses at cycle 1; scan_en is never asserted.
- abort in CAPTURE:
  - Next cycle all outputs are 0 and busy=0, with no done pulse.
  - A fresh start with N=1 then completes normally.
- rst pulled low mid-UNLOAD: outputs go to 0 immediately, without waiting for a clk edge; start is ignored while rst=0.
